// File: rtl/gift_ctrl.sv
// Falling power-up controller: arms on a spawn request, drops the gift on each frame tick,
// and reports a paddle catch or a fall-out as one-cycle registered pulses.
module gift_ctrl #(
  parameter int LEFT      = 100,
  parameter int TOP       = 40,
  parameter int MAXX      = 440,
  parameter int MAXY      = 400,
  parameter int GIFT_H    = 8,
  parameter int PAD_HW    = 32,
  parameter int PAD_HH    = 4,
  parameter int FALL_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       clear,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [2:0] spawn_kind,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] kind,
  output logic       active,
  output logic       caught,
  output logic [2:0] caught_kind,
  output logic       missed
);

  typedef enum logic {
    IDLE = 1'b0,
    FALL = 1'b1
  } state_t;

  localparam logic [10:0] CATCH_DY  = 11'(GIFT_H + PAD_HH);
  localparam logic [10:0] CATCH_DX  = 11'(GIFT_H + PAD_HW);
  localparam logic [10:0] MISS_Y    = 11'(TOP + MAXY + GIFT_H);
  localparam logic [10:0] STEP      = 11'(FALL_STEP);

  state_t      state, state_nx;
  logic [9:0]  x_nx, y_nx;
  logic [2:0]  kind_nx, caught_kind_nx;
  logic        caught_nx, missed_nx;

  // Geometry is evaluated 11 bits wide so the next y never wraps and the
  // differences carry a sign bit; bit 10 of each difference is its sign.
  logic [10:0] ny, dy, dx, ady, adx;
  logic        hit, fell;

  always_comb begin
    ny   = {1'b0, y} + STEP;
    dy   = ny - {1'b0, paddle_y};
    dx   = {1'b0, x} - {1'b0, paddle_x};
    ady  = dy[10] ? (~dy + 11'd1) : dy;
    adx  = dx[10] ? (~dx + 11'd1) : dx;
    hit  = (ady < CATCH_DY) && (adx < CATCH_DX);
    fell = (ny >= MISS_Y);
  end

  always_comb begin
    state_nx       = state;
    x_nx           = x;
    y_nx           = y;
    kind_nx        = kind;
    caught_nx      = 1'b0;
    caught_kind_nx = 3'd0;
    missed_nx      = 1'b0;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (spawn && (spawn_kind != 3'd0)) begin
            state_nx = FALL;
            x_nx     = spawn_x;
            y_nx     = spawn_y;
            kind_nx  = spawn_kind;
          end
        end
        FALL: begin
          if (frame_tick) begin
            y_nx = ny[9:0];
            // Catch is checked first so a gift touching the paddle at the bottom counts.
            if (hit) begin
              state_nx       = IDLE;
              caught_nx      = 1'b1;
              caught_kind_nx = kind;
            end else if (fell) begin
              state_nx  = IDLE;
              missed_nx = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= 10'd0;
      y           <= 10'd0;
      kind        <= 3'd0;
      caught      <= 1'b0;
      caught_kind <= 3'd0;
      missed      <= 1'b0;
    end else begin
      state       <= state_nx;
      x           <= x_nx;
      y           <= y_nx;
      kind        <= kind_nx;
      caught      <= caught_nx;
      caught_kind <= caught_kind_nx;
      missed      <= missed_nx;
    end
  end

  // The two-state FSM is directly visible as the renderer enable.
  assign active = (state == FALL);

endmodule

// File: tb/tb_gift_ctrl.sv
// Directed and random checks of gift_ctrl against a cycle model feeding an expected-output queue.
module tb_gift_ctrl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, clear, spawn;
  logic [9:0] spawn_x, spawn_y, paddle_x, paddle_y;
  logic [2:0] spawn_kind;
  logic [9:0] x, y;
  logic [2:0] kind, caught_kind;
  logic       active, caught, missed;

  int checks = 0;
  int errors = 0;

  logic [28:0] exp_q[$];

  int m_x = 0, m_y = 0, m_kind = 0, m_act = 0, m_c = 0, m_ck = 0, m_m = 0;

  always #5 clk = ~clk;

  gift_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .clear(clear),
    .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_kind(spawn_kind),
    .paddle_x(paddle_x), .paddle_y(paddle_y),
    .x(x), .y(y), .kind(kind), .active(active),
    .caught(caught), .caught_kind(caught_kind), .missed(missed)
  );

  function automatic logic [28:0] pack(int px, int py, int pk, int pa, int pc, int pck, int pm);
    logic [28:0] v;
    v = {10'(px), 10'(py), 3'(pk), 1'(pa), 1'(pc), 3'(pck), 1'(pm)};
    return v;
  endfunction

  // Model of one clock edge, computed from the inputs as currently driven.
  task automatic model_step();
    int ny, ady, adx;
    m_c  = 0;
    m_ck = 0;
    m_m  = 0;
    if (rst) begin
      m_x = 0; m_y = 0; m_kind = 0; m_act = 0;
    end else if (clear) begin
      m_act = 0;
    end else if (m_act == 0) begin
      if (spawn && spawn_kind != 0) begin
        m_x = int'(spawn_x); m_y = int'(spawn_y); m_kind = int'(spawn_kind); m_act = 1;
      end
    end else if (frame_tick) begin
      ny  = m_y + 2;
      ady = ny - int'(paddle_y);
      if (ady < 0) ady = -ady;
      adx = m_x - int'(paddle_x);
      if (adx < 0) adx = -adx;
      m_y = ny % 1024;
      if (ady < 12 && adx < 40) begin
        m_c = 1; m_ck = m_kind; m_act = 0;
      end else if (ny >= 448) begin
        m_m = 1; m_act = 0;
      end
    end
    exp_q.push_back(pack(m_x, m_y, m_kind, m_act, m_c, m_ck, m_m));
  endtask

  task automatic cycle(string tag);
    logic [28:0] e, o;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {x, y, kind, active, caught, caught_kind, missed};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk(string tag, logic [9:0] obs, logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_gap(string tag);
    frame_tick = 1'b1;
    cycle(tag);
    frame_tick = 1'b0;
    cycle({tag, "_gap"});
  endtask

  task automatic set_spawn(logic [9:0] sx, logic [9:0] sy, logic [2:0] sk);
    spawn = 1'b1; spawn_x = sx; spawn_y = sy; spawn_kind = sk;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; clear = 1'b0; spawn = 1'b0;
    spawn_x = '0; spawn_y = '0; spawn_kind = '0; paddle_x = 10'd210; paddle_y = 10'd140;
    cycle("reset");
    cycle("reset_hold");
    rst = 1'b0;
    chk("reset_active", 10'(active), 10'd0);
    chk("reset_x", x, 10'd0);

    // Spawn with a coincident tick: loads without moving.
    set_spawn(10'd200, 10'd100, 3'd3);
    frame_tick = 1'b1;
    cycle("spawn1");
    spawn = 1'b0; frame_tick = 1'b0;
    chk("spawn1_active", 10'(active), 10'd1);
    chk("spawn1_x", x, 10'd200);
    chk("spawn1_y", y, 10'd100);
    chk("spawn1_kind", 10'(kind), 10'd3);
    for (int i = 0; i < 10; i++) tick_gap("fall");
    chk("fall_y120", y, 10'd120);

    set_spawn(10'd300, 10'd50, 3'd5);
    cycle("spawn_in_fall");
    spawn = 1'b0;
    chk("ignore_x", x, 10'd200);
    chk("ignore_kind", 10'(kind), 10'd3);

    for (int i = 0; i < 4; i++) tick_gap("approach");
    chk("approach_y", y, 10'd128);
    chk("approach_nocatch", 10'(caught), 10'd0);
    frame_tick = 1'b1;
    cycle("catch");
    frame_tick = 1'b0;
    chk("catch_pulse", 10'(caught), 10'd1);
    chk("catch_kind", 10'(caught_kind), 10'd3);
    chk("catch_active", 10'(active), 10'd0);
    chk("catch_y", y, 10'd130);
    cycle("catch_end");
    chk("catch_pulse_end", 10'(caught), 10'd0);
    chk("catch_kind_end", 10'(caught_kind), 10'd0);

    set_spawn(10'd250, 10'd200, 3'd0);
    cycle("spawn_kind0");
    spawn = 1'b0;
    chk("kind0_active", 10'(active), 10'd0);

    // Fall-out at the bottom edge with the paddle far away.
    paddle_x = 10'd400; paddle_y = 10'd440;
    set_spawn(10'd200, 10'd440, 3'd2);
    cycle("spawn_miss");
    spawn = 1'b0;
    for (int i = 0; i < 3; i++) tick_gap("sink");
    chk("sink_nomiss", 10'(missed), 10'd0);
    frame_tick = 1'b1;
    cycle("miss");
    frame_tick = 1'b0;
    chk("miss_pulse", 10'(missed), 10'd1);
    chk("miss_nocatch", 10'(caught), 10'd0);
    chk("miss_active", 10'(active), 10'd0);
    chk("miss_y", y, 10'd448);
    cycle("miss_end");
    chk("miss_pulse_end", 10'(missed), 10'd0);

    // Clear wins over a tick that would otherwise catch.
    paddle_x = 10'd210; paddle_y = 10'd140;
    set_spawn(10'd200, 10'd128, 3'd4);
    cycle("spawn_clear");
    spawn = 1'b0;
    clear = 1'b1; frame_tick = 1'b1;
    cycle("clear");
    clear = 1'b0; frame_tick = 1'b0;
    chk("clear_active", 10'(active), 10'd0);
    chk("clear_caught", 10'(caught), 10'd0);
    chk("clear_missed", 10'(missed), 10'd0);
    cycle("clear_after");
    chk("clear_after_caught", 10'(caught), 10'd0);

    // Reset mid-fall with a coincident spawn.
    set_spawn(10'd200, 10'd100, 3'd6);
    cycle("spawn_rst");
    spawn = 1'b0;
    tick_gap("pre_rst");
    rst = 1'b1;
    set_spawn(10'd300, 10'd200, 3'd7);
    cycle("rst_mid");
    chk("rst_x", x, 10'd0);
    chk("rst_y", y, 10'd0);
    chk("rst_kind", 10'(kind), 10'd0);
    chk("rst_active", 10'(active), 10'd0);
    rst = 1'b0;
    cycle("spawn_after_rst");
    spawn = 1'b0;
    chk("post_rst_active", 10'(active), 10'd1);
    chk("post_rst_x", x, 10'd300);
    chk("post_rst_kind", 10'(kind), 10'd7);

    // Random traffic; spawns land near the paddle often enough to exercise catches.
    for (int i = 0; i < 400; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      clear      = ($urandom_range(0, 40) == 0);
      spawn      = ($urandom_range(0, 5) == 0);
      spawn_x    = 10'($urandom_range(100, 540));
      spawn_y    = 10'($urandom_range(40, 460));
      spawn_kind = 3'($urandom_range(0, 7));
      paddle_x   = 10'($urandom_range(100, 540));
      paddle_y   = 10'($urandom_range(300, 460));
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
